// File: rtl/nibbler_pkg.sv
// nibbler_pkg: types and constants shared by the button conditioning blocks.
//   NUM_BTN                  number of push buttons on the board
//   btn_t                    one bit per button
//   DEFAULT_DEBOUNCE_CYCLES  default acceptance window in clk cycles
//   db_state_e               per-bit debounce FSM state encoding
package nibbler_pkg;

    localparam int NUM_BTN = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    typedef logic [NUM_BTN-1:0] btn_t;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/button_debouncer_if.sv
// button_debouncer_if: button path between the board pins, the debouncer and IN.
//   btn_raw   raw asynchronous button levels, 1 = pressed
//   ack       port-read strobe from IN (only used by the latched build)
//   buttons   conditioned button vector
//   btn_rise  one-cycle strobe per accepted press
// master drives the raw side and reads results; slave is the debouncer.
interface button_debouncer_if;
    import nibbler_pkg::*;

    btn_t btn_raw;
    logic ack;
    btn_t buttons;
    btn_t btn_rise;

    modport master (output btn_raw, output ack, input buttons, input btn_rise);
    modport slave  (input btn_raw, input ack, output buttons, output btn_rise);

endinterface

// File: rtl/debounce_bit.sv
// debounce_bit: one button's two-flop synchronizer, debounce counter,
// accepted level and registered rise strobe.
//   clk, rst_n  system clock, async active-low reset
//   btn_raw     raw asynchronous button level
//   level       debounced level (stable_q)
//   rise        one-cycle pulse following a 0->1 acceptance
//
// state       | meaning
// ST_STABLE   | s2 matches the accepted level, counter parked at 0
// ST_COUNTING | s2 differs, counter advancing toward DEBOUNCE_CYCLES-1
module debounce_bit
    import nibbler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    db_state_e        state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            state <= ST_STABLE;
        end else begin
            s1   <= btn_raw;
            s2   <= s1;
            rise <= 1'b0;
            case (state)
                ST_STABLE: begin
                    // First differing sample counts as sample 1; DEBOUNCE_CYCLES >= 2
                    // means this can never already be the accepting sample.
                    if (s2 != level) begin
                        cnt   <= cnt + CNT_W'(1);
                        state <= ST_COUNTING;
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_COUNTING: begin
                    if (s2 == level) begin
                        // Bounce back to the old level: reject and restart.
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end else if (cnt == CNT_LAST) begin
                        level <= s2;
                        rise  <= s2;
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_STABLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: conditions the four raw push buttons for the IN port.
// One debounce_bit per button, plus an optional sticky-press layer.
//   clk, rst_n  system clock, async active-low reset
//   bus         button_debouncer_if.slave (btn_raw, ack in; buttons, btn_rise out)
// Build option BTN_LATCH_EN: buttons[i] becomes a flag set by btn_rise[i]
// and cleared by ack (set wins on the same edge). Without it, buttons is
// the debounced level and ack is ignored.
module button_debouncer
    import nibbler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
    input logic clk,
    input logic rst_n,
    button_debouncer_if.slave bus
);

    btn_t stable_q;
    btn_t rise_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W(CNT_W)
        ) u_bit (
            .clk(clk),
            .rst_n(rst_n),
            .btn_raw(bus.btn_raw[i]),
            .level(stable_q[i]),
            .rise(rise_q[i])
        );
    end

    assign bus.btn_rise = rise_q;

`ifdef BTN_LATCH_EN
    btn_t latch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_q <= '0;
        end else begin
            // Set has priority so a press arriving with the read is kept.
            latch_q <= (latch_q & ~{NUM_BTN{bus.ack}}) | rise_q;
        end
    end

    assign bus.buttons = latch_q;
`else
    logic unused_ack;
    assign unused_ack  = bus.ack;
    assign bus.buttons = stable_q;
`endif

endmodule
